// File: rtl/iterst_bit_serializer_pkg.sv
// Shared definitions for the iterSt bit serializer: defaults, word type, shifter states
// and the occupancy-counter width helper.
package iterst_ser_pkg;

  localparam int   DEF_WIDTH    = 8;
  localparam int   DEF_DEPTH    = 2;
  localparam logic DEF_IDLE_BIT = 1'b0;

  typedef logic [DEF_WIDTH-1:0] word_t;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } ser_state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iterst_bit_serializer_if.sv
// Word-in / bit-out bundle of the serializer; master is the feeder side, slave is the block.
interface iterst_bit_serializer_if
  import iterst_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_active;
  logic             ser_first;
  logic             ser_last;
  logic [CW-1:0]    fifo_count;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_bit, ser_active, ser_first, ser_last, fifo_count
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_bit, ser_active, ser_first, ser_last, fifo_count
  );

endinterface

// File: rtl/iterst_word_fifo.sv
// Synchronous word FIFO; storage is not reset, only pointers and occupancy are.
module iterst_word_fifo
  import iterst_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iterst_bit_serializer.sv
// Buffers WIDTH-bit words and streams them LSB-first, one bit per clock, into the
// handshake-free iterSt stage; back-to-back words leave no gap.
module iterst_bit_serializer
  import iterst_ser_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter int   DEPTH    = DEF_DEPTH,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input logic                      clk,
  input logic                      rst,
  iterst_bit_serializer_if.slave   bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic             busy;
  logic             at_last;
  logic             load;

  assign busy    = state == ST_SHIFT;
  assign at_last = idx == LAST_IDX;
  // Reloading on the last bit is what makes consecutive words seamless.
  assign load    = !empty && (!busy || at_last);
  assign pop     = load;

  assign bus.in_ready   = !rst && !full;
  assign push           = bus.in_valid && bus.in_ready;
  assign bus.fifo_count = count;

  iterst_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SHIFT;
      ST_SHIFT: if (!load && at_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 idx <= '0;
    else if (load)           idx <= '0;
    else if (busy)           idx <= at_last ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load) shreg <= head;
  end

  always_comb begin
    bus.ser_bit    = IDLE_BIT;
    bus.ser_active = busy;
    bus.ser_first  = busy && (idx == '0);
    bus.ser_last   = busy && at_last;
    if (busy) bus.ser_bit = shreg[idx];
  end

endmodule

// File: tb/tb_iterst_bit_serializer.sv
// Directed bench: two serializers (IDLE_BIT 0 and 1) share stimulus; per-DUT queues of
// expected {bit,first,last} are drained by a negedge monitor.
module tb_iterst_bit_serializer;
  import iterst_ser_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int run0     = 0;
  int max_run0 = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  iterst_bit_serializer_if #(.WIDTH(8), .DEPTH(2)) bus0 ();
  iterst_bit_serializer_if #(.WIDTH(8), .DEPTH(2)) bus1 ();

  assign bus1.in_data  = bus0.in_data;
  assign bus1.in_valid = bus0.in_valid;

  iterst_bit_serializer #(.WIDTH(8), .DEPTH(2), .IDLE_BIT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  iterst_bit_serializer #(.WIDTH(8), .DEPTH(2), .IDLE_BIT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic enqueue(input word_t w);
    for (int i = 0; i < 8; i++) begin
      q0.push_back({w[i], i == 0, i == 7});
      q1.push_back({w[i], i == 0, i == 7});
    end
  endtask

  task automatic mon(input int id, input logic act, input logic b, input logic f,
                     input logic l, input logic idle);
    logic [2:0] got;
    logic [2:0] exp;
    int         sz;
    got = {b, f, l};
    if (id == 0) begin
      run0 = act ? run0 + 1 : 0;
      if (run0 > max_run0) max_run0 = run0;
    end
    if (act) begin
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_checks++;
        $display("FAIL ser%0d_unexpected: got active bits=%b expected idle", id, got);
      end else begin
        exp = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("ser%0d_bit_first_last", id), int'(got), int'(exp));
      end
    end else begin
      chk($sformatf("ser%0d_idle", id), int'(got), int'({idle, 2'b00}));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus0.ser_active, bus0.ser_bit, bus0.ser_first, bus0.ser_last, 1'b0);
      mon(1, bus1.ser_active, bus1.ser_bit, bus1.ser_first, bus1.ser_last, 1'b1);
    end
  end

  // Holds in_valid until the block accepts the word; called at posedge+1.
  task automatic push(input word_t w);
    logic acc;
    acc = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = w;
    for (int i = 0; i < 40; i++) begin
      if (bus0.in_ready) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) break;
    end
    bus0.in_valid = 1'b0;
    if (acc) enqueue(w);
    else chk($sformatf("push_accept_%02h", w), 0, 1);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic ok;
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;

    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("in_ready_in_reset", int'(bus0.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", int'(bus0.in_ready), 1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_fifo_count", int'(bus0.fifo_count), 0);
      chk("idle_in_ready", int'(bus0.in_ready), 1);
    end

    // Single word 0xA5 and its first-bit latency
    push(8'hA5);
    chk("a5_not_yet_active", int'(bus0.ser_active), 0);
    @(posedge clk); #1;
    chk("a5_first_latency", int'({bus0.ser_first, bus0.ser_bit}), 3);
    drain(12);
    chk("a5_drained", q0.size(), 0);

    // Three consecutive words must stream without gaps
    max_run0 = 0;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    drain(30);
    chk("b2b_run_length", max_run0, 24);
    chk("b2b_drained", q0.size(), 0);

    // Fill the FIFO while busy, then wait for the next load to free a slot
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("full_count", int'(bus0.fifo_count), 2);
    chk("full_in_ready", int'(bus0.in_ready), 0);
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'h44;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.in_ready) begin
        ok = 1'b1;
        chk("ready_on_load_first", int'(bus0.ser_first), 1);
        chk("ready_on_load_count", int'(bus0.fifo_count), 1);
        break;
      end
      @(posedge clk); #1;
    end
    chk("ready_returns", int'(ok), 1);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    if (ok) enqueue(8'h44);
    drain(40);
    chk("full_drained", q0.size(), 0);

    // Reset during bit 3 of 0x3C with one word queued
    push(8'h3C);
    push(8'h77);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.ser_first) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_wait_first", int'(ok), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_bit3", int'(bus0.ser_bit), 1);
    rst = 1'b1;
    #1;
    chk("rst_in_ready_comb", int'(bus0.in_ready), 0);
    @(posedge clk); #1;
    chk("rst_active", int'(bus0.ser_active), 0);
    chk("rst_bit", int'(bus0.ser_bit), 0);
    chk("rst_count", int'(bus0.fifo_count), 0);
    chk("rst_in_ready", int'(bus0.in_ready), 0);
    q0.delete();
    q1.delete();
    rst = 1'b0;
    drain(3);
    chk("rst_no_residue", int'(bus0.ser_active), 0);
    push(8'h5A);
    drain(14);
    chk("post_rst_drained", q0.size(), 0);

    // 0xC3 exercises the IDLE_BIT=1 instance alongside the default one
    push(8'hC3);
    drain(14);
    chk("c3_drained0", q0.size(), 0);
    chk("c3_drained1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
